// File: rtl/shiftreg_seq_pkg.sv
// Shared codes for the shift-register command sequencer: shift ops,
// shiftreg_u mode selects and FSM state encodings.
package shiftreg_seq_pkg;

    typedef logic [2:0] op_t;
    typedef logic [1:0] mode_t;
    typedef logic [1:0] state_t;

    localparam op_t OP_SHL = 3'b000;
    localparam op_t OP_SHR = 3'b001;
    localparam op_t OP_ROL = 3'b010;
    localparam op_t OP_ROR = 3'b011;
    localparam op_t OP_ASR = 3'b100;

    localparam mode_t MODE_HOLD  = 2'b00;
    localparam mode_t MODE_RIGHT = 2'b01;
    localparam mode_t MODE_LEFT  = 2'b10;
    localparam mode_t MODE_LOAD  = 2'b11;

    localparam state_t ST_IDLE  = 2'b00;
    localparam state_t ST_LOAD  = 2'b01;
    localparam state_t ST_SHIFT = 2'b10;
    localparam state_t ST_DONE  = 2'b11;

    // Unrecognised op codes behave as SHL, so they shift left too.
    function automatic mode_t shift_mode(input op_t op);
        mode_t m;
        case (op)
            OP_SHR, OP_ROR, OP_ASR: m = MODE_RIGHT;
            default:                m = MODE_LEFT;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/shiftreg_seq_if.sv
// Command channel from a host to the shift-register sequencer.
interface shiftreg_seq_if #(
    parameter int W     = 4,
    parameter int CNT_W = 3
);
    // Handshake: a command transfers on a rising clk edge where cmd_valid and
    // cmd_ready are both high. The host holds cmd_valid and all cmd_* fields
    // stable until that edge; cmd_ready does not depend on cmd_valid.
    logic             cmd_valid;
    logic             cmd_ready;
    logic [2:0]       cmd_op;
    logic             cmd_load;
    logic [W-1:0]     cmd_data;
    logic [CNT_W-1:0] cmd_cnt;
    logic             cmd_fill;

    modport master (
        output cmd_valid, cmd_op, cmd_load, cmd_data, cmd_cnt, cmd_fill,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_load, cmd_data, cmd_cnt, cmd_fill,
        output cmd_ready
    );
endinterface

// File: rtl/shiftreg_u.sv
// 4-mode universal shift register: hold, shift right, shift left, parallel load.
module shiftreg_u #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [1:0]   s_i,
    input  logic [W-1:0] d_i,
    input  logic         lin_i,
    input  logic         rin_i,
    output logic [W-1:0] q_o
);
    logic [W-1:0] q_q, q_d;

    always_comb begin
        q_d = q_q;
        case (s_i)
            2'b01:   q_d = {lin_i, q_q[W-1:1]};
            2'b10:   q_d = {q_q[W-2:0], rin_i};
            2'b11:   q_d = d_i;
            default: q_d = q_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) q_q <= '0;
        else        q_q <= q_d;
    end

    assign q_o = q_q;
endmodule

// File: rtl/shiftreg_seq.sv
// Command sequencer for shiftreg_u: accepts one shift/rotate command, optionally
// loads a start value, steps the register cnt times and reports the result.
module shiftreg_seq
    import shiftreg_seq_pkg::*;
#(
    parameter int W     = 4,
    parameter int CNT_W = 3
) (
    input  logic         clk,
    input  logic         rst_n,
    shiftreg_seq_if.slave cmd,
    output logic [1:0]   sr_s,
    output logic [W-1:0] sr_d,
    output logic         sr_lin,
    output logic         sr_rin,
    input  logic [W-1:0] sr_q,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] result,
    output logic [1:0]   dbg_state
);
    state_t           state_q, state_d;
    op_t              op_q, op_d;
    logic [W-1:0]     data_q, data_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             fill_q, fill_d;
    logic [W-1:0]     result_q, result_d;
    logic             accept;

    assign cmd.cmd_ready = (state_q == ST_IDLE);
    assign accept        = cmd.cmd_valid && cmd.cmd_ready;

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        data_d   = data_q;
        cnt_d    = cnt_q;
        fill_d   = fill_q;
        result_d = result_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    op_d   = cmd.cmd_op;
                    data_d = cmd.cmd_data;
                    cnt_d  = cmd.cmd_cnt;
                    fill_d = cmd.cmd_fill;
                    if (cmd.cmd_load)            state_d = ST_LOAD;
                    else if (cmd.cmd_cnt != '0)  state_d = ST_SHIFT;
                    else                         state_d = ST_DONE;
                end
            end
            ST_LOAD: begin
                state_d = (cnt_q != '0) ? ST_SHIFT : ST_DONE;
            end
            ST_SHIFT: begin
                // cnt_q counts the shift edges still owed, including this one.
                cnt_d = cnt_q - 1'b1;
                if (cnt_q <= 1) state_d = ST_DONE;
            end
            ST_DONE: begin
                result_d = sr_q;
                state_d  = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            op_q     <= '0;
            data_q   <= '0;
            cnt_q    <= '0;
            fill_q   <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            data_q   <= data_d;
            cnt_q    <= cnt_d;
            fill_q   <= fill_d;
            result_q <= result_d;
        end
    end

    always_comb begin
        sr_s = MODE_HOLD;
        case (state_q)
            ST_LOAD:  sr_s = MODE_LOAD;
            ST_SHIFT: sr_s = shift_mode(op_q);
            default:  sr_s = MODE_HOLD;
        endcase
    end

    // Serial inputs follow the latched op; the side not fed by the op stays 0.
    always_comb begin
        sr_lin = 1'b0;
        sr_rin = 1'b0;
        case (op_q)
            OP_SHR:  sr_lin = fill_q;
            OP_ROL:  sr_rin = sr_q[W-1];
            OP_ROR:  sr_lin = sr_q[0];
            OP_ASR:  sr_lin = sr_q[W-1];
            default: sr_rin = fill_q;
        endcase
    end

    assign sr_d      = data_q;
    assign busy      = (state_q != ST_IDLE);
    assign done      = (state_q == ST_DONE);
    assign result    = result_q;
    assign dbg_state = state_q;
endmodule

// File: tb/tb_shiftreg_seq.sv
// Directed bench for shiftreg_seq driving a shiftreg_u instance.
module tb_shiftreg_seq;
    import shiftreg_seq_pkg::*;

    localparam int W     = 4;
    localparam int CNT_W = 3;

    logic         clk;
    logic         rst_n;
    logic [1:0]   sr_s;
    logic [W-1:0] sr_d;
    logic         sr_lin;
    logic         sr_rin;
    logic [W-1:0] sr_q;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic [1:0]   dbg_state;

    int n_vec  = 0;
    int n_miss = 0;
    int acc_cnt = 0;
    int acc_base;
    logic [W-1:0] exp_q[$];
    logic [1:0]   mode_log[$];

    shiftreg_seq_if #(.W(W), .CNT_W(CNT_W)) cmd_if ();

    shiftreg_seq #(.W(W), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd       (cmd_if),
        .sr_s      (sr_s),
        .sr_d      (sr_d),
        .sr_lin    (sr_lin),
        .sr_rin    (sr_rin),
        .sr_q      (sr_q),
        .busy      (busy),
        .done      (done),
        .result    (result),
        .dbg_state (dbg_state)
    );

    shiftreg_u #(.W(W)) u_sr (
        .clk   (clk),
        .rst_n (rst_n),
        .s_i   (sr_s),
        .d_i   (sr_d),
        .lin_i (sr_lin),
        .rin_i (sr_rin),
        .q_o   (sr_q)
    );

    // Clock and accept counter
    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (cmd_if.cmd_valid && cmd_if.cmd_ready) acc_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_miss++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input op_t op, input logic ld, input logic [W-1:0] data,
                         input logic [CNT_W-1:0] cnt, input logic fill);
        cmd_if.cmd_valid = 1'b1;
        cmd_if.cmd_op    = op;
        cmd_if.cmd_load  = ld;
        cmd_if.cmd_data  = data;
        cmd_if.cmd_cnt   = cnt;
        cmd_if.cmd_fill  = fill;
    endtask

    // Issue one command, count edges from the accept edge to done, then
    // score sr_q at done and result on the following cycle.
    task automatic run_cmd(input string tag, input op_t op, input logic ld,
                           input logic [W-1:0] data, input logic [CNT_W-1:0] cnt,
                           input logic fill, input logic [W-1:0] exp_res, input int exp_lat);
        int lat;
        logic seen;
        logic [W-1:0] exp_v;
        mode_log.delete();
        @(negedge clk);
        drive(op, ld, data, cnt, fill);
        check({tag, " ready"}, 32'(cmd_if.cmd_ready), 32'd1);
        @(posedge clk);
        #1 cmd_if.cmd_valid = 1'b0;
        exp_q.push_back(exp_res);
        lat  = 0;
        seen = 1'b0;
        while (!seen && lat < 40) begin
            @(negedge clk);
            lat++;
            mode_log.push_back(sr_s);
            if (done) seen = 1'b1;
        end
        exp_v = exp_q.pop_front();
        check({tag, " done seen"}, 32'(seen), 32'd1);
        check({tag, " latency"}, 32'(lat), 32'(exp_lat));
        check({tag, " sr_q at done"}, 32'(sr_q), 32'(exp_v));
        @(negedge clk);
        check({tag, " result"}, 32'(result), 32'(exp_v));
        check({tag, " done pulse"}, 32'(done), 32'd0);
        check({tag, " idle ready"}, 32'(cmd_if.cmd_ready), 32'd1);
    endtask

    initial begin
        cmd_if.cmd_valid = 1'b0;
        cmd_if.cmd_op    = '0;
        cmd_if.cmd_load  = 1'b0;
        cmd_if.cmd_data  = '0;
        cmd_if.cmd_cnt   = '0;
        cmd_if.cmd_fill  = 1'b0;
        rst_n = 1'b0;
        #1;
        check("rst sr_s", 32'(sr_s), 32'd0);
        check("rst busy", 32'(busy), 32'd0);
        check("rst done", 32'(done), 32'd0);
        check("rst result", 32'(result), 32'd0);
        check("rst ready", 32'(cmd_if.cmd_ready), 32'd1);
        check("rst state", 32'(dbg_state), 32'(ST_IDLE));
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // 1: load + SHL 1
        run_cmd("t1 shl", OP_SHL, 1'b1, 4'b0101, 3'd1, 1'b0, 4'b1010, 3);
        check("t1 mode load", 32'(mode_log[0]), 32'(MODE_LOAD));
        check("t1 mode left", 32'(mode_log[1]), 32'(MODE_LEFT));
        check("t1 mode done", 32'(mode_log[2]), 32'(MODE_HOLD));

        // 2: ROR, then rotate by W is identity
        run_cmd("t2 ror1", OP_ROR, 1'b1, 4'b1001, 3'd1, 1'b0, 4'b1100, 3);
        check("t2 mode right", 32'(mode_log[1]), 32'(MODE_RIGHT));
        run_cmd("t2 ror4", OP_ROR, 1'b0, 4'b0000, 3'd4, 1'b0, 4'b1100, 5);

        // 3: ASR keeps sign, SHR shifts fill in
        run_cmd("t3 asr", OP_ASR, 1'b1, 4'b1000, 3'd2, 1'b0, 4'b1110, 4);
        run_cmd("t3 shr", OP_SHR, 1'b1, 4'b0000, 3'd2, 1'b1, 4'b1100, 4);

        // 4: cnt=0 with and without load
        run_cmd("t4 load0", OP_SHL, 1'b1, 4'b0110, 3'd0, 1'b0, 4'b0110, 2);
        check("t4 load0 mode", 32'(mode_log[0]), 32'(MODE_LOAD));
        run_cmd("t4 noload0", OP_SHL, 1'b0, 4'b1111, 3'd0, 1'b1, 4'b0110, 1);
        check("t4 noload0 mode", 32'(mode_log[0]), 32'(MODE_HOLD));
        check("t4 noload0 log", 32'(mode_log.size()), 32'd1);

        // Undefined op acts as SHL; max count rotate
        run_cmd("op111", 3'b111, 1'b1, 4'b0001, 3'd2, 1'b1, 4'b0111, 4);
        run_cmd("rol7", OP_ROL, 1'b1, 4'b1100, 3'd7, 1'b0, 4'b0110, 9);

        // 5: valid held through busy, second command right after done
        acc_base = acc_cnt;
        @(negedge clk);
        drive(OP_SHL, 1'b1, 4'b0011, 3'd1, 1'b1);
        check("t5 ready a", 32'(cmd_if.cmd_ready), 32'd1);
        @(posedge clk);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("t5 ready busy", 32'(cmd_if.cmd_ready), 32'd0);
            check("t5 busy", 32'(busy), 32'd1);
        end
        @(negedge clk);
        check("t5 done a", 32'(done), 32'd1);
        check("t5 ready done", 32'(cmd_if.cmd_ready), 32'd0);
        check("t5 sr_q a", 32'(sr_q), 32'b0111);
        drive(OP_ROL, 1'b0, 4'b0000, 3'd1, 1'b0);
        @(negedge clk);
        check("t5 ready b", 32'(cmd_if.cmd_ready), 32'd1);
        check("t5 result a", 32'(result), 32'b0111);
        check("t5 single accept", 32'(acc_cnt - acc_base), 32'd1);
        @(posedge clk);
        #1 cmd_if.cmd_valid = 1'b0;
        @(negedge clk);
        check("t5 busy b", 32'(busy), 32'd1);
        @(negedge clk);
        check("t5 done b", 32'(done), 32'd1);
        check("t5 sr_q b", 32'(sr_q), 32'b1110);
        @(negedge clk);
        check("t5 result b", 32'(result), 32'b1110);
        check("t5 two accepts", 32'(acc_cnt - acc_base), 32'd2);

        // 6: reset in the middle of a long shift
        @(negedge clk);
        drive(OP_SHL, 1'b1, 4'b1111, 3'd7, 1'b0);
        @(posedge clk);
        #1 cmd_if.cmd_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("t6 mid shift", 32'(sr_s), 32'(MODE_LEFT));
        rst_n = 1'b0;
        #1;
        check("t6 rst sr_s", 32'(sr_s), 32'd0);
        check("t6 rst busy", 32'(busy), 32'd0);
        check("t6 rst result", 32'(result), 32'd0);
        check("t6 rst sr_d", 32'(sr_d), 32'd0);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("t6 no done", 32'(done), 32'd0);
        end
        rst_n = 1'b1;
        @(negedge clk);
        check("t6 ready after", 32'(cmd_if.cmd_ready), 32'd1);
        check("t6 no done after", 32'(done), 32'd0);
        run_cmd("t6 rol", OP_ROL, 1'b1, 4'b0011, 3'd2, 1'b0, 4'b1100, 4);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
